// File: rtl/axi4_mst_bridge_pkg.sv
// Shared definitions for the AXI4 master bridge: FSM encoding, AXI response and burst codes.
// The optional ID/rlast checker is enabled in the top by defining AXI4_MST_ERR_CHK_EN.
package axi4_mst_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/axi4_beat_cnt.sv
// Burst beat counter: cleared on command accept, counts accepted beats, flags the last beat.
// One bit wider than the len field so a 256-beat burst never wraps.
module axi4_beat_cnt #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             last_o
);

    logic [LEN_W:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == {1'b0, len_i});

endmodule

// File: rtl/axi4_mst_bridge.sv
// Single-outstanding AXI4 master: command + data streams in, one INCR burst out at a time.
// Define AXI4_MST_ERR_CHK_EN to check returned IDs and rlast position (any mismatch reports SLVERR).
//
// state      | meaning
// ST_IDLE    | waiting for a command (cmd_rdy_o high once out of reset)
// ST_WR_ADDR | AW valid with registered id/addr/len
// ST_WR_DATA | write stream passed through to W, counting beats
// ST_WR_RESP | waiting for B, response captured
// ST_RD_ADDR | AR valid with registered id/addr/len
// ST_RD_DATA | R passed through to read stream, worst rresp accumulated
// ST_DONE    | one-cycle done_o pulse with final response
module axi4_mst_bridge
    import axi4_mst_bridge_pkg::*;
#(
    parameter int DATA_W           = 8,
    parameter int ADDR_W           = 32,
    parameter int MST_ID_W         = 5,
    parameter int TRANS_DATA_LEN_W = 8,
    parameter int TRANS_RESP_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_vld_i,
    output logic                        cmd_rdy_o,
    input  logic                        cmd_wr_i,
    input  logic [MST_ID_W-1:0]         cmd_id_i,
    input  logic [ADDR_W-1:0]           cmd_addr_i,
    input  logic [TRANS_DATA_LEN_W-1:0] cmd_len_i,
    input  logic [DATA_W-1:0]           wr_data_i,
    input  logic                        wr_vld_i,
    output logic                        wr_rdy_o,
    output logic [DATA_W-1:0]           rd_data_o,
    output logic                        rd_last_o,
    output logic                        rd_vld_o,
    input  logic                        rd_rdy_i,
    output logic                        done_o,
    output logic [TRANS_RESP_W-1:0]     done_resp_o,
    output logic [MST_ID_W-1:0]         s_awid_o,
    output logic [ADDR_W-1:0]           s_awaddr_o,
    output logic [TRANS_DATA_LEN_W-1:0] s_awlen_o,
    output logic                        s_awvalid_o,
    input  logic                        s_awready_i,
    output logic [DATA_W-1:0]           s_wdata_o,
    output logic                        s_wlast_o,
    output logic                        s_wvalid_o,
    input  logic                        s_wready_i,
    input  logic [MST_ID_W-1:0]         s_bid_i,
    input  logic [TRANS_RESP_W-1:0]     s_bresp_i,
    input  logic                        s_bvalid_i,
    output logic                        s_bready_o,
    output logic [MST_ID_W-1:0]         s_arid_o,
    output logic [ADDR_W-1:0]           s_araddr_o,
    output logic [TRANS_DATA_LEN_W-1:0] s_arlen_o,
    output logic                        s_arvalid_o,
    input  logic                        s_arready_i,
    input  logic [MST_ID_W-1:0]         s_rid_i,
    input  logic [DATA_W-1:0]           s_rdata_i,
    input  logic [TRANS_RESP_W-1:0]     s_rresp_i,
    input  logic                        s_rlast_i,
    input  logic                        s_rvalid_i,
    output logic                        s_rready_o
);

    state_e                        state_q, state_d;
    logic [MST_ID_W-1:0]           id_q, id_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic [TRANS_DATA_LEN_W-1:0]   len_q, len_d;
    logic [TRANS_RESP_W-1:0]       resp_q, resp_d;
    logic                          err_q, err_d;
    logic                          rst_done_q;
    logic                          cmd_hs, w_hs, r_hs;
    logic                          beat_last, r_end, r_err, b_err;

    assign cmd_hs = cmd_vld_i & cmd_rdy_o;
    assign w_hs   = (state_q == ST_WR_DATA) & wr_vld_i & s_wready_i;
    assign r_hs   = (state_q == ST_RD_DATA) & s_rvalid_i & rd_rdy_i;

    axi4_beat_cnt #(
        .LEN_W (TRANS_DATA_LEN_W)
    ) u_beat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cmd_hs),
        .inc_i  (w_hs | r_hs),
        .len_i  (len_q),
        .last_o (beat_last)
    );

`ifdef AXI4_MST_ERR_CHK_EN
    // The counter bounds the burst even if the slave never raises rlast.
    assign r_end = s_rlast_i | beat_last;
    assign r_err = (s_rid_i != id_q) | (s_rlast_i != beat_last);
    assign b_err = (s_bid_i != id_q);
`else
    logic unused_ids;
    assign unused_ids = ^{s_bid_i, s_rid_i};
    assign r_end      = s_rlast_i;
    assign r_err      = 1'b0;
    assign b_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            resp_q     <= '0;
            err_q      <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            resp_q     <= resp_d;
            err_q      <= err_d;
            rst_done_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        resp_d  = resp_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    id_d    = cmd_id_i;
                    addr_d  = cmd_addr_i;
                    len_d   = cmd_len_i;
                    resp_d  = TRANS_RESP_W'(RESP_OKAY);
                    err_d   = 1'b0;
                    state_d = cmd_wr_i ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: if (s_awready_i) state_d = ST_WR_DATA;
            ST_WR_DATA: if (w_hs && beat_last) state_d = ST_WR_RESP;
            ST_WR_RESP: begin
                if (s_bvalid_i) begin
                    resp_d  = s_bresp_i;
                    err_d   = b_err;
                    state_d = ST_DONE;
                end
            end
            ST_RD_ADDR: if (s_arready_i) state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                if (r_hs) begin
                    resp_d = (s_rresp_i > resp_q) ? s_rresp_i : resp_q;
                    err_d  = err_q | r_err;
                    if (r_end) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_rdy_o   = 1'b0;
        s_awvalid_o = 1'b0;
        s_wvalid_o  = 1'b0;
        s_wdata_o   = '0;
        s_wlast_o   = 1'b0;
        wr_rdy_o    = 1'b0;
        s_bready_o  = 1'b0;
        s_arvalid_o = 1'b0;
        rd_vld_o    = 1'b0;
        rd_data_o   = '0;
        rd_last_o   = 1'b0;
        s_rready_o  = 1'b0;
        done_o      = 1'b0;
        done_resp_o = '0;
        unique case (state_q)
            ST_IDLE:    cmd_rdy_o = rst_done_q;
            ST_WR_ADDR: s_awvalid_o = 1'b1;
            ST_WR_DATA: begin
                s_wvalid_o = wr_vld_i;
                s_wdata_o  = wr_data_i;
                s_wlast_o  = beat_last;
                wr_rdy_o   = s_wready_i;
            end
            ST_WR_RESP: s_bready_o = 1'b1;
            ST_RD_ADDR: s_arvalid_o = 1'b1;
            ST_RD_DATA: begin
                rd_vld_o   = s_rvalid_i;
                rd_data_o  = s_rdata_i;
                rd_last_o  = s_rlast_i;
                s_rready_o = rd_rdy_i;
            end
            ST_DONE: begin
                done_o      = 1'b1;
                done_resp_o = err_q ? TRANS_RESP_W'(RESP_SLVERR) : resp_q;
            end
            default: ;
        endcase
    end

    assign s_awid_o   = id_q;
    assign s_awaddr_o = addr_q;
    assign s_awlen_o  = len_q;
    assign s_arid_o   = id_q;
    assign s_araddr_o = addr_q;
    assign s_arlen_o  = len_q;

endmodule

// File: tb/tb_axi4_mst_bridge.sv
// Bench for axi4_mst_bridge: table of directed transactions, a reset-abort sequence and
// random transactions against a memory slave and a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_axi4_mst_bridge;

`ifdef AXI4_MST_ERR_CHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_vld_i, cmd_rdy_o, cmd_wr_i;
    logic [4:0]  cmd_id_i;
    logic [31:0] cmd_addr_i;
    logic [7:0]  cmd_len_i;
    logic [7:0]  wr_data_i;
    logic        wr_vld_i, wr_rdy_o;
    logic [7:0]  rd_data_o;
    logic        rd_last_o, rd_vld_o, rd_rdy_i;
    logic        done_o;
    logic [1:0]  done_resp_o;
    logic [4:0]  s_awid_o, s_bid_i, s_arid_o, s_rid_i;
    logic [31:0] s_awaddr_o, s_araddr_o;
    logic [7:0]  s_awlen_o, s_arlen_o, s_wdata_o, s_rdata_i;
    logic        s_awvalid_o, s_awready_i, s_wlast_o, s_wvalid_o, s_wready_i;
    logic [1:0]  s_bresp_i, s_rresp_i;
    logic        s_bvalid_i, s_bready_o, s_arvalid_o, s_arready_i;
    logic        s_rlast_i, s_rvalid_i, s_rready_o;

    always #5 clk = ~clk;

    axi4_mst_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o), .cmd_wr_i(cmd_wr_i),
        .cmd_id_i(cmd_id_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wr_data_i(wr_data_i), .wr_vld_i(wr_vld_i), .wr_rdy_o(wr_rdy_o),
        .rd_data_o(rd_data_o), .rd_last_o(rd_last_o), .rd_vld_o(rd_vld_o), .rd_rdy_i(rd_rdy_i),
        .done_o(done_o), .done_resp_o(done_resp_o),
        .s_awid_o(s_awid_o), .s_awaddr_o(s_awaddr_o), .s_awlen_o(s_awlen_o),
        .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready_i),
        .s_wdata_o(s_wdata_o), .s_wlast_o(s_wlast_o), .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i),
        .s_bid_i(s_bid_i), .s_bresp_i(s_bresp_i), .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o),
        .s_arid_o(s_arid_o), .s_araddr_o(s_araddr_o), .s_arlen_o(s_arlen_o),
        .s_arvalid_o(s_arvalid_o), .s_arready_i(s_arready_i),
        .s_rid_i(s_rid_i), .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i), .s_rlast_i(s_rlast_i),
        .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Knobs for the slave / stream agents
    bit         slv_all_rdy = 1'b0;
    bit         wr_all_vld = 1'b0;
    int         rd_rdy_mode = 0;      // 0 random, 1 always, 2 toggle
    int         inj_rbeat = -1;
    logic [1:0] inj_rresp = 2'b00;
    logic [1:0] inj_bresp = 2'b00;
    logic [4:0] inj_idx = 5'd0;

    // Slave state and memories
    bit [7:0]    slv_mem [bit [31:0]];
    bit [7:0]    ref_mem [bit [31:0]];
    bit          w_act, b_pend, r_act;
    logic [4:0]  aw_id_c, ar_id_c;
    logic [31:0] aw_addr_c, ar_addr_c;
    logic [7:0]  aw_len_c, ar_len_c;
    int          wbeat, rbeat, done_cnt;
    logic [7:0]  wq[$];
    logic [8:0]  rq[$];

    initial begin : agent
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_hs, rd_hs;
        logic [7:0]  wd, rdd, len_s;
        logic        wl, rdl;
        logic [4:0]  id_s;
        logic [31:0] addr_s;
        s_awready_i = 0; s_wready_i = 0; s_bvalid_i = 0; s_bid_i = '0; s_bresp_i = '0;
        s_arready_i = 0; s_rvalid_i = 0; s_rid_i = '0; s_rdata_i = '0; s_rresp_i = '0; s_rlast_i = 0;
        wr_vld_i = 0; wr_data_i = '0; rd_rdy_i = 0;
        w_act = 0; b_pend = 0; r_act = 0; wbeat = 0; rbeat = 0; done_cnt = 0;
        forever begin
            @(negedge clk);
            aw_hs = s_awvalid_o && s_awready_i;
            ar_hs = s_arvalid_o && s_arready_i;
            id_s = s_awvalid_o ? s_awid_o : s_arid_o;
            addr_s = s_awvalid_o ? s_awaddr_o : s_araddr_o;
            len_s = s_awvalid_o ? s_awlen_o : s_arlen_o;
            w_hs = s_wvalid_o && s_wready_i; wd = s_wdata_o; wl = s_wlast_o;
            b_hs = s_bvalid_i && s_bready_o;
            r_hs = s_rvalid_i && s_rready_o;
            wr_hs = wr_vld_i && wr_rdy_o;
            rd_hs = rd_vld_o && rd_rdy_i; rdd = rd_data_o; rdl = rd_last_o;
            if (done_o) done_cnt++;
            @(posedge clk); #1;
            if (!rst_n) begin
                w_act = 0; b_pend = 0; r_act = 0;
                s_awready_i = 0; s_wready_i = 0; s_bvalid_i = 0; s_arready_i = 0; s_rvalid_i = 0;
                wr_vld_i = 0; rd_rdy_i = 0;
                continue;
            end
            if (aw_hs) begin
                aw_id_c = id_s; aw_addr_c = addr_s; aw_len_c = len_s; wbeat = 0; w_act = 1;
            end
            if (w_hs) begin
                chk("w_in_burst", 32'(w_act), 1);
                chk("wlast", 32'(wl), 32'(wbeat == int'(aw_len_c)));
                slv_mem[aw_addr_c + 32'(wbeat)] = wd;
                if (wbeat == int'(aw_len_c)) begin w_act = 0; b_pend = 1; end
                wbeat++;
            end
            if (wr_hs) void'(wq.pop_front());
            if (b_hs) b_pend = 0;
            if (ar_hs) begin
                ar_id_c = id_s; ar_addr_c = addr_s; ar_len_c = len_s; rbeat = 0; r_act = 1;
            end
            if (r_hs) begin
                if (rbeat == int'(ar_len_c)) r_act = 0;
                rbeat++;
            end
            if (rd_hs) rq.push_back({rdl, rdd});

            s_awready_i = slv_all_rdy ? 1'b1 : 1'($urandom_range(0, 1));
            s_arready_i = slv_all_rdy ? 1'b1 : 1'($urandom_range(0, 1));
            s_wready_i  = w_act && (slv_all_rdy || 1'($urandom_range(0, 1)));
            if (!b_pend) s_bvalid_i = 0;
            else if (!s_bvalid_i) s_bvalid_i = slv_all_rdy ? 1'b1 : 1'($urandom_range(0, 1));
            s_bid_i = aw_id_c; s_bresp_i = inj_bresp;
            if (!r_act) s_rvalid_i = 0;
            else if (!s_rvalid_i || r_hs) s_rvalid_i = slv_all_rdy ? 1'b1 : 1'($urandom_range(0, 1));
            s_rdata_i = slv_mem[ar_addr_c + 32'(rbeat)];
            s_rlast_i = (rbeat == int'(ar_len_c));
            s_rresp_i = (rbeat == inj_rbeat) ? inj_rresp : 2'b00;
            s_rid_i   = ar_id_c ^ inj_idx;
            wr_vld_i  = (wq.size() > 0) && (wr_all_vld || 1'($urandom_range(0, 1)));
            wr_data_i = (wq.size() > 0) ? wq[0] : 8'h00;
            case (rd_rdy_mode)
                1: rd_rdy_i = 1'b1;
                2: rd_rdy_i = ~rd_rdy_i;
                default: rd_rdy_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic issue_cmd(input bit wr, input logic [4:0] id, input logic [31:0] addr,
                             input logic [7:0] len, output bit ok);
        int t;
        @(posedge clk); #1;
        cmd_vld_i = 1; cmd_wr_i = wr; cmd_id_i = id; cmd_addr_i = addr; cmd_len_i = len;
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_rdy_o && t < 50);
        ok = cmd_rdy_o;
        if (!ok) chk("cmd_accept_timeout", 32'(cmd_rdy_o), 1);
        @(posedge clk); #1;
        cmd_vld_i = 0;
    endtask

    task automatic run_txn(input bit wr, input logic [4:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [7:0] d0, input bit rand_data,
                           input logic [1:0] exp_resp);
        int n, t;
        bit ok;
        logic [7:0] b;
        n = int'(len) + 1;
        rq.delete();
        if (wr) begin
            for (int i = 0; i < n; i++) begin
                b = rand_data ? 8'($urandom) : 8'(d0 + 8'(8'h11 * i));
                wq.push_back(b);
                ref_mem[addr + 32'(i)] = b;
            end
        end
        issue_cmd(wr, id, addr, len, ok);
        if (!ok) return;
        @(negedge clk);
        chk("cmd_rdy_busy", 32'(cmd_rdy_o), 0);
        chk(wr ? "awvalid_n1" : "arvalid_n1", 32'(wr ? s_awvalid_o : s_arvalid_o), 1);
        chk("addr_out", wr ? s_awaddr_o : s_araddr_o, addr);
        t = 0;
        while (!done_o && t < 5000) begin @(negedge clk); t++; end
        if (!done_o) begin
            chk("done_timeout", 32'(done_o), 1);
            return;
        end
        chk("done_resp", 32'(done_resp_o), 32'(exp_resp));
        @(negedge clk);
        chk("done_one_cycle", 32'(done_o), 0);
        chk("cmd_rdy_after_done", 32'(cmd_rdy_o), 1);
        if (wr) begin
            chk("aw_id", 32'(aw_id_c), 32'(id));
            chk("aw_len", 32'(aw_len_c), 32'(len));
            chk("w_beats", 32'(wbeat), 32'(n));
            chk("wq_drained", 32'(wq.size()), 0);
        end else begin
            chk("ar_id", 32'(ar_id_c), 32'(id));
            chk("ar_len", 32'(ar_len_c), 32'(len));
            chk("rd_beats", 32'(rq.size()), 32'(n));
            for (int i = 0; i < rq.size(); i++) begin
                chk("rd_data", 32'(rq[i][7:0]), 32'(ref_mem[addr + 32'(i)]));
                chk("rd_last", 32'(rq[i][8]), 32'(i == n - 1));
            end
        end
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [7:0]  d0;
        int          rmode;
        bit          all_rdy;
        int          rbeat_err;
        logic [1:0]  rresp_err;
        logic [1:0]  bresp;
        logic [4:0]  idx;
        logic [1:0]  exp;
    } vec_t;

    vec_t vtab [0:8];

    initial begin : main
        int t, dc0;
        bit ok;
        logic [7:0] ln;
        logic [1:0] er;
        vtab[0] = '{1'b1, 5'd3, 32'h2300_0000, 8'd3,   8'h11, 1, 1'b1, -1, 2'b00, 2'b00, 5'd0, 2'b00};
        vtab[1] = '{1'b0, 5'd3, 32'h2300_0000, 8'd3,   8'h00, 2, 1'b0, -1, 2'b00, 2'b00, 5'd0, 2'b00};
        vtab[2] = '{1'b1, 5'd3, 32'h2300_0100, 8'd0,   8'hA5, 0, 1'b0, -1, 2'b00, 2'b00, 5'd0, 2'b00};
        vtab[3] = '{1'b0, 5'd3, 32'h2300_0100, 8'd0,   8'h00, 0, 1'b0, -1, 2'b00, 2'b00, 5'd0, 2'b00};
        vtab[4] = '{1'b0, 5'd3, 32'h2300_0000, 8'd3,   8'h00, 0, 1'b0,  1, 2'b10, 2'b00, 5'd0, 2'b10};
        vtab[5] = '{1'b0, 5'd3, 32'h2300_0000, 8'd3,   8'h00, 1, 1'b1, -1, 2'b00, 2'b00, 5'd7,
                    ERRCHK ? 2'b10 : 2'b00};
        vtab[6] = '{1'b1, 5'd9, 32'h2300_0200, 8'd7,   8'h10, 0, 1'b0, -1, 2'b00, 2'b10, 5'd0, 2'b10};
        vtab[7] = '{1'b1, 5'd1, 32'h2300_1000, 8'd255, 8'h01, 1, 1'b1, -1, 2'b00, 2'b00, 5'd0, 2'b00};
        vtab[8] = '{1'b0, 5'd1, 32'h2300_1000, 8'd255, 8'h00, 0, 1'b0, -1, 2'b00, 2'b00, 5'd0, 2'b00};

        cmd_vld_i = 0; cmd_wr_i = 0; cmd_id_i = '0; cmd_addr_i = '0; cmd_len_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_rdy", 32'(cmd_rdy_o), 0);
        chk("rst_awvalid", 32'(s_awvalid_o), 0);
        chk("rst_arvalid", 32'(s_arvalid_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_done_resp", 32'(done_resp_o), 0);
        chk("rst_awaddr", s_awaddr_o, 0);
        chk("rst_arlen", 32'(s_arlen_o), 0);
        rst_n = 1;

        for (int i = 0; i <= 8; i++) begin
            @(posedge clk); #1;
            slv_all_rdy = vtab[i].all_rdy; wr_all_vld = vtab[i].all_rdy;
            rd_rdy_mode = vtab[i].rmode; inj_rbeat = vtab[i].rbeat_err;
            inj_rresp = vtab[i].rresp_err; inj_bresp = vtab[i].bresp; inj_idx = vtab[i].idx;
            run_txn(vtab[i].wr, vtab[i].id, vtab[i].addr, vtab[i].len, vtab[i].d0, 1'b0, vtab[i].exp);
        end

        // Reset while the second write beat is on the bus: burst abandoned, no done pulse.
        slv_all_rdy = 1; wr_all_vld = 1; inj_rbeat = -1; inj_bresp = 0; inj_idx = 0;
        dc0 = done_cnt;
        for (int i = 0; i < 4; i++) wq.push_back(8'(8'h60 + i));
        issue_cmd(1'b1, 5'd2, 32'h3000_0000, 8'd3, ok);
        t = 0;
        while (!(w_act && wbeat == 1) && t < 50) begin @(negedge clk); t++; end
        chk("pre_rst_wvalid", 32'(s_wvalid_o), 1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_wvalid", 32'(s_wvalid_o), 0);
        chk("rst_mid_wlast", 32'(s_wlast_o), 0);
        chk("rst_mid_wrrdy", 32'(wr_rdy_o), 0);
        chk("rst_mid_awvalid", 32'(s_awvalid_o), 0);
        chk("rst_mid_bready", 32'(s_bready_o), 0);
        chk("rst_mid_cmd_rdy", 32'(cmd_rdy_o), 0);
        chk("rst_mid_awaddr", s_awaddr_o, 0);
        wq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1;
        t = 0;
        while (!cmd_rdy_o && t < 5) begin @(negedge clk); t++; end
        chk("cmd_rdy_after_rst", 32'(cmd_rdy_o), 1);
        chk("no_done_after_abort", 32'(done_cnt), 32'(dc0));
        chk("wvalid_after_rst", 32'(s_wvalid_o), 0);

        slv_all_rdy = 0; wr_all_vld = 0; rd_rdy_mode = 0;
        for (int k = 0; k < 24; k++) begin
            ln = 8'($urandom_range(0, 15));
            er = 2'($urandom_range(1, 3));
            inj_idx = 0;
            if ($urandom_range(0, 1) == 1) begin
                inj_bresp = 2'b00; inj_rbeat = -1;
                if ($urandom_range(0, 2) == 0) inj_bresp = er;
                run_txn(1'b1, 5'($urandom), 32'h1000 + 32'($urandom_range(0, 63)), ln, 8'h00, 1'b1, inj_bresp);
            end else begin
                inj_rbeat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(ln))) : -1;
                inj_rresp = er;
                run_txn(1'b0, 5'($urandom), 32'h1000 + 32'($urandom_range(0, 63)), ln, 8'h00, 1'b0,
                        (inj_rbeat >= 0) ? er : 2'b00);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
